// File: rtl/decoder_seq.sv
// decoder_seq: multi-cycle opcode microsequencer driving the datapath control bus
module decoder_seq #(
  parameter int                DATA_W     = 8,
  parameter int                STEP_W     = 2,
  parameter logic [DATA_W-1:0] NOP_OPCODE = DATA_W'(8'hEA),
  parameter bit                ENABLE_ABS = 1'b1,
  parameter bit                ILL_STICKY = 1'b0
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              normal,
  input  logic              flush,
  input  logic              ready,
  input  logic [DATA_W-1:0] instruction,
  output logic              w_rd,
  output logic              pc_data,
  output logic              increment,
  output logic              lower_byte,
  output logic              x_con,
  output logic              y_con,
  output logic              accumulator_con,
  output logic              status_con,
  output logic              stack_pointer_con,
  output logic              branch_uncon,
  output logic              branch_con,
  output logic [2:0]        branch_op,
  output logic [3:0]        alu_op,
  output logic [1:0]        operand_mux_con,
  output logic              addr_lat_lo,
  output logic              addr_lat_hi,
  output logic              sync,
  output logic              illegal,
  output logic [STEP_W-1:0] step
);
  localparam logic [3:0] ADC = 4'd1, SBC = 4'd2, AND = 4'd3, EOR = 4'd4, ORA = 4'd5, PASS = 4'd11;

  logic [DATA_W-1:0] ir_q, ir_d;
  logic [STEP_W-1:0] step_q, step_d, s;
  logic              ill_q, ill_d;
  logic              adc_i, sbc_i, and_i, ora_i, eor_i, lda_i, ldx_i, ldy_i;
  logic              imm, zp, ab, nop, ill, adc_mem, t0, t1, t2, mem, imm_t1, alu_wr, cont;

  function automatic logic op_is(input logic [DATA_W-1:0] ir, input logic [7:0] op);
    return ir == DATA_W'(op);
  endfunction

  assign adc_i   = op_is(ir_q, 8'h69);
  assign sbc_i   = op_is(ir_q, 8'hE9);
  assign and_i   = op_is(ir_q, 8'h29);
  assign ora_i   = op_is(ir_q, 8'h09);
  assign eor_i   = op_is(ir_q, 8'h49);
  assign lda_i   = op_is(ir_q, 8'hA9);
  assign ldx_i   = op_is(ir_q, 8'hA2);
  assign ldy_i   = op_is(ir_q, 8'hA0);
  assign imm     = adc_i | sbc_i | and_i | ora_i | eor_i | lda_i | ldx_i | ldy_i;
  assign zp      = op_is(ir_q, 8'h65) | op_is(ir_q, 8'h85);
  assign ab      = ENABLE_ABS && (op_is(ir_q, 8'h6D) | op_is(ir_q, 8'h8D));
  assign nop     = op_is(ir_q, 8'hEA);
  assign ill     = !(imm | zp | ab | nop);
  assign adc_mem = op_is(ir_q, 8'h65) | op_is(ir_q, 8'h6D);

  // normal=0 presents the fetch step on the outputs before the state register catches up
  assign s       = normal ? step_q : '0;
  assign t0      = s == '0;
  assign t1      = s == STEP_W'(1);
  assign t2      = s == STEP_W'(2);
  assign mem     = (zp && t2) || (ab && s == STEP_W'(3));
  assign imm_t1  = imm && t1;
  assign alu_wr  = imm_t1 || (mem && adc_mem);
  assign cont    = (zp && t1) || (ab && (t1 || t2));

  assign sync              = t0;
  assign pc_data           = !mem;
  assign increment         = ready && !(t1 && (nop || ill)) && !mem;
  assign w_rd              = ready && mem && !adc_mem;
  assign addr_lat_lo       = ready && t1 && (zp || ab);
  assign addr_lat_hi       = ready && t2 && ab;
  assign x_con             = ready && imm_t1 && ldx_i;
  assign y_con             = ready && imm_t1 && ldy_i;
  assign accumulator_con   = ready && alu_wr && !(imm_t1 && (ldx_i || ldy_i));
  assign status_con        = ready && alu_wr;
  assign operand_mux_con   = alu_wr ? 2'd3 : 2'd0;
  assign alu_op            = imm_t1 ? ((lda_i | ldx_i | ldy_i) ? PASS : sbc_i ? SBC : and_i ? AND :
                                       eor_i ? EOR : ora_i ? ORA : ADC)
                           : mem ? (adc_mem ? ADC : PASS) : 4'd0;
  assign illegal           = ill_q || (t1 && ill);
  assign step              = s;
  assign lower_byte        = 1'b0;
  assign stack_pointer_con = 1'b0;
  assign branch_uncon      = 1'b0;
  assign branch_con        = 1'b0;
  assign branch_op         = 3'd0;

  always_comb begin
    ill_d  = ill_q || (ILL_STICKY && t1 && ill);
    ir_d   = (!normal || flush) ? NOP_OPCODE : (ready && t0) ? instruction : ir_q;
    step_d = !normal ? '0 : flush ? STEP_W'(1) : !ready ? step_q : t0 ? STEP_W'(1) :
             cont ? step_q + 1'b1 : '0;
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      ir_q   <= NOP_OPCODE;
      step_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      step_q <= step_d;
      ill_q  <= ill_d;
    end
  end
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed-vector bench for decoder_seq, plus an ENABLE_ABS=0 instance
module tb_decoder_seq;
  logic clk_1 = 1'b0;
  logic rst = 1'b0, rst2 = 1'b0, normal = 1'b1, flush = 1'b0, ready = 1'b1;
  logic [7:0] instruction = 8'h00, instruction2 = 8'h6D;
  logic w_rd, pc_data, increment, lower_byte, x_con, y_con, accumulator_con, status_con;
  logic stack_pointer_con, branch_uncon, branch_con, addr_lat_lo, addr_lat_hi, sync, illegal;
  logic [2:0] branch_op;
  logic [3:0] alu_op;
  logic [1:0] operand_mux_con, step;
  logic w_rd2, pc_data2, increment2, lower_byte2, x_con2, y_con2, accumulator_con2, status_con2;
  logic stack_pointer_con2, branch_uncon2, branch_con2, addr_lat_lo2, addr_lat_hi2, sync2, illegal2;
  logic [2:0] branch_op2;
  logic [3:0] alu_op2;
  logic [1:0] operand_mux_con2, step2;
  logic [25:0] act, act2;
  int total = 0, bad = 0;

  always #5 clk_1 = ~clk_1;

  decoder_seq dut (
    .clk_1(clk_1), .rst(rst), .normal(normal), .flush(flush), .ready(ready), .instruction(instruction),
    .w_rd(w_rd), .pc_data(pc_data), .increment(increment), .lower_byte(lower_byte),
    .x_con(x_con), .y_con(y_con), .accumulator_con(accumulator_con), .status_con(status_con),
    .stack_pointer_con(stack_pointer_con), .branch_uncon(branch_uncon), .branch_con(branch_con),
    .branch_op(branch_op), .alu_op(alu_op), .operand_mux_con(operand_mux_con),
    .addr_lat_lo(addr_lat_lo), .addr_lat_hi(addr_lat_hi), .sync(sync), .illegal(illegal), .step(step)
  );

  decoder_seq #(.ENABLE_ABS(1'b0)) dut_noabs (
    .clk_1(clk_1), .rst(rst2), .normal(normal), .flush(flush), .ready(ready), .instruction(instruction2),
    .w_rd(w_rd2), .pc_data(pc_data2), .increment(increment2), .lower_byte(lower_byte2),
    .x_con(x_con2), .y_con(y_con2), .accumulator_con(accumulator_con2), .status_con(status_con2),
    .stack_pointer_con(stack_pointer_con2), .branch_uncon(branch_uncon2), .branch_con(branch_con2),
    .branch_op(branch_op2), .alu_op(alu_op2), .operand_mux_con(operand_mux_con2),
    .addr_lat_lo(addr_lat_lo2), .addr_lat_hi(addr_lat_hi2), .sync(sync2), .illegal(illegal2), .step(step2)
  );

  assign act  = {lower_byte, stack_pointer_con, branch_uncon, branch_con, branch_op, sync, illegal, w_rd,
                 pc_data, increment, addr_lat_lo, addr_lat_hi, x_con, y_con, accumulator_con, status_con,
                 alu_op, operand_mux_con, step};
  assign act2 = {lower_byte2, stack_pointer_con2, branch_uncon2, branch_con2, branch_op2, sync2, illegal2,
                 w_rd2, pc_data2, increment2, addr_lat_lo2, addr_lat_hi2, x_con2, y_con2, accumulator_con2,
                 status_con2, alu_op2, operand_mux_con2, step2};

  function automatic logic [25:0] ev(input bit sy, il, wr, pc, inc, lo, hi, x, y, a, st,
                                     input logic [3:0] alu, input logic [1:0] mux, stp);
    return {7'b0, sy, il, wr, pc, inc, lo, hi, x, y, a, st, alu, mux, stp};
  endfunction

  localparam logic [25:0] T0    = ev(1,0,0,1,1,0,0,0,0,0,0, 0,0,0);
  localparam logic [25:0] T0S   = ev(1,0,0,1,0,0,0,0,0,0,0, 0,0,0);
  localparam logic [25:0] ADC1  = ev(0,0,0,1,1,0,0,0,0,1,1, 1,3,1);
  localparam logic [25:0] LAT1  = ev(0,0,0,1,1,1,0,0,0,0,0, 0,0,1);
  localparam logic [25:0] ABS2  = ev(0,0,0,1,1,0,1,0,0,0,0, 0,0,2);
  localparam logic [25:0] ABS3  = ev(0,0,0,0,0,0,0,0,0,1,1, 1,3,3);
  localparam logic [25:0] STALL = ev(0,0,0,0,0,0,0,0,0,0,0,11,0,2);
  localparam logic [25:0] STA2  = ev(0,0,1,0,0,0,0,0,0,0,0,11,0,2);
  localparam logic [25:0] ADCZ2 = ev(0,0,0,0,0,0,0,0,0,1,1, 1,3,2);
  localparam logic [25:0] EOR1  = ev(0,0,0,1,1,0,0,0,0,1,1, 4,3,1);
  localparam logic [25:0] LDY1  = ev(0,0,0,1,1,0,0,0,1,0,1,11,3,1);
  localparam logic [25:0] LDX1  = ev(0,0,0,1,1,0,0,1,0,0,1,11,3,1);
  localparam logic [25:0] NOP1  = ev(0,0,0,1,0,0,0,0,0,0,0, 0,0,1);
  localparam logic [25:0] ILL1  = ev(0,1,0,1,0,0,0,0,0,0,0, 0,0,1);

  task automatic chk(input string tag, input logic [25:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] ins, input string tag, input logic [25:0] exp);
    instruction = ins;
    #1 chk(tag, act, exp);
    @(posedge clk_1) #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    instruction = 8'h69;
    #2 chk("rst", act, T0);
    chk("rst2", act2, T0);
    rst = 1'b1;
    @(posedge clk_1) #1;
    cyc(8'h05, "adc_t1", ADC1);
    cyc(8'h6D, "adc_sync", T0);
    cyc(8'h34, "abs_t1", LAT1);
    cyc(8'h12, "abs_t2", ABS2);
    cyc(8'h00, "abs_t3", ABS3);
    cyc(8'h85, "abs_sync", T0);
    cyc(8'h10, "sta_t1", LAT1);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(8'h00, "sta_stall", STALL);
    ready = 1'b1;
    cyc(8'h00, "sta_t2", STA2);
    ready = 1'b0;
    cyc(8'h65, "t0_stall", T0S);
    ready = 1'b1;
    cyc(8'h65, "zp_sync", T0);
    cyc(8'h10, "zp_t1", LAT1);
    cyc(8'h00, "zp_t2", ADCZ2);
    cyc(8'h49, "eor_sync", T0);
    cyc(8'h33, "eor_t1", EOR1);
    cyc(8'hA0, "ldy_sync", T0);
    cyc(8'h01, "ldy_t1", LDY1);
    cyc(8'h6D, "fl_sync", T0);
    cyc(8'h34, "fl_t1", LAT1);
    flush = 1'b1;
    cyc(8'h12, "fl_t2", ABS2);
    flush = 1'b0;
    cyc(8'h00, "fl_nop", NOP1);
    cyc(8'h6D, "fl_done", T0);
    instruction = 8'h34;
    #1 chk("rst_t1", act, LAT1);
    #1 rst = 1'b0;
    #1 chk("rst_async", act, T0);
    instruction = 8'h02;
    #1 rst = 1'b1;
    @(posedge clk_1) #1;
    cyc(8'h00, "ill_t1", ILL1);
    cyc(8'h6D, "ill_done", T0);
    cyc(8'h34, "nm_t1", LAT1);
    normal = 1'b0;
    cyc(8'h12, "nm0_a", T0);
    cyc(8'h12, "nm0_b", T0);
    normal = 1'b1;
    cyc(8'hA2, "ldx_sync", T0);
    cyc(8'h7F, "ldx_t1", LDX1);
    cyc(8'h00, "ldx_done", T0);
    rst2 = 1'b1;
    @(posedge clk_1) #1;
    chk("abs_off_t1", act2, ILL1);
    @(posedge clk_1) #1;
    chk("abs_off_sync", act2, T0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
